// File: rtl/labs_range_search.sv
// rtl/labs_range_search.sv - LABS range search engine
//
// Sweeps binary sequences cur = start, start+stride, ... <= end. For each candidate
// it accumulates the aperiodic-autocorrelation energy E = sum_k C_k^2 (one lag per
// cycle) and keeps the minimum. In mode 1 it stops at the first E <= threshold.
//
// Ports:
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   start_i, abort_i        launch (IDLE only) / cancel a search
//   cfg_mode_i              0 = full-range minimum, 1 = stop at first E <= cfg_thresh_i
//   cfg_start_i/end_i       inclusive candidate range
//   cfg_stride_i            increment (0 behaves as 1)
//   cfg_thresh_i            mode-1 threshold
//   busy_o, done_o          searching / one-cycle completion pulse
//   found_o                 mode-1 hit
//   best_seq_o, best_e_o    best (or first-hit) sequence and its energy
//   eval_cnt_o              candidates fully evaluated in this run
module labs_range_search #(
  parameter int SEQ_WIDTH = 16,
  parameter int E_WIDTH   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 cfg_mode_i,
  input  logic [SEQ_WIDTH-1:0] cfg_start_i,
  input  logic [SEQ_WIDTH-1:0] cfg_end_i,
  input  logic [SEQ_WIDTH-1:0] cfg_stride_i,
  input  logic [E_WIDTH-1:0]   cfg_thresh_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 found_o,
  output logic [SEQ_WIDTH-1:0] best_seq_o,
  output logic [E_WIDTH-1:0]   best_e_o,
  output logic [SEQ_WIDTH:0]   eval_cnt_o
);

  localparam int KW  = $clog2(SEQ_WIDTH) + 1;
  localparam int SQW = 2 * KW;
  // Sum width leaves one spare bit above both operands so saturation can be detected.
  localparam int SW  = ((E_WIDTH > SQW) ? E_WIDTH : SQW) + 1;
  localparam logic [E_WIDTH-1:0] E_MAX  = '1;
  localparam logic [KW-1:0]      K_LAST = KW'(SEQ_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_UPDATE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SEQ_WIDTH-1:0] cur_q, cur_d;
  logic [SEQ_WIDTH-1:0] end_q, end_d;
  logic [SEQ_WIDTH-1:0] stride_q, stride_d;
  logic [E_WIDTH-1:0]   thresh_q, thresh_d;
  logic                 mode_q, mode_d;
  logic [KW-1:0]        k_q, k_d;
  logic [E_WIDTH-1:0]   acc_q, acc_d;
  logic [SEQ_WIDTH-1:0] best_seq_q, best_seq_d;
  logic [E_WIDTH-1:0]   best_e_q, best_e_d;
  logic                 found_q, found_d;
  logic [SEQ_WIDTH:0]   eval_cnt_q, eval_cnt_d;

  // Correlation term for the current lag k:
  // C_k = (N-k) - 2 * (number of disagreeing pairs s_i, s_{i+k}).
  logic [SEQ_WIDTH-1:0] mask;
  logic [SEQ_WIDTH-1:0] diff;
  int                   pop;
  int                   c_int;
  int                   c_abs;
  logic [SW-1:0]        sq;
  logic [SW-1:0]        sum;
  logic [E_WIDTH-1:0]   acc_next;

  always_comb begin
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      mask[i] = (i < (SEQ_WIDTH - int'(k_q)));
    end
    diff     = (cur_q ^ (cur_q >> k_q)) & mask;
    pop      = $countones(diff);
    c_int    = (SEQ_WIDTH - int'(k_q)) - 2 * pop;
    c_abs    = (c_int < 0) ? -c_int : c_int;
    sq       = SW'(c_abs * c_abs);
    sum      = SW'(acc_q) + sq;
    acc_next = (sum > SW'(E_MAX)) ? E_MAX : sum[E_WIDTH-1:0];
  end

  // Next candidate carries one extra bit so a range ending at all-ones cannot wrap.
  logic [SEQ_WIDTH:0] nxt;
  logic               past_end;
  logic               hit;

  assign nxt      = {1'b0, cur_q} + {1'b0, stride_q};
  assign past_end = nxt > {1'b0, end_q};
  assign hit      = mode_q && (acc_q <= thresh_q);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    stride_d   = stride_q;
    thresh_d   = thresh_q;
    mode_d     = mode_q;
    k_d        = k_q;
    acc_d      = acc_q;
    best_seq_d = best_seq_q;
    best_e_d   = best_e_q;
    found_d    = found_q;
    eval_cnt_d = eval_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          cur_d      = cfg_start_i;
          end_d      = cfg_end_i;
          stride_d   = (cfg_stride_i == '0) ? SEQ_WIDTH'(1) : cfg_stride_i;
          thresh_d   = cfg_thresh_i;
          mode_d     = cfg_mode_i;
          k_d        = KW'(1);
          acc_d      = '0;
          best_seq_d = '0;
          best_e_d   = E_MAX;
          found_d    = 1'b0;
          eval_cnt_d = '0;
          state_d    = (cfg_end_i < cfg_start_i) ? S_DONE : S_EVAL;
        end
      end
      S_EVAL: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_next;
          if (k_q == K_LAST) begin
            k_d     = KW'(1);
            state_d = S_UPDATE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_UPDATE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          eval_cnt_d = eval_cnt_q + 1'b1;
          // Strict compare: on ties the earlier candidate stays best.
          if (hit || (acc_q < best_e_q)) begin
            best_seq_d = cur_q;
            best_e_d   = acc_q;
          end
          if (hit) begin
            found_d = 1'b1;
            state_d = S_DONE;
          end else if (past_end) begin
            state_d = S_DONE;
          end else begin
            cur_d   = nxt[SEQ_WIDTH-1:0];
            acc_d   = '0;
            state_d = S_EVAL;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      stride_q   <= '0;
      thresh_q   <= '0;
      mode_q     <= 1'b0;
      k_q        <= KW'(1);
      acc_q      <= '0;
      best_seq_q <= '0;
      best_e_q   <= E_MAX;
      found_q    <= 1'b0;
      eval_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      stride_q   <= stride_d;
      thresh_q   <= thresh_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      best_seq_q <= best_seq_d;
      best_e_q   <= best_e_d;
      found_q    <= found_d;
      eval_cnt_q <= eval_cnt_d;
    end
  end

  assign busy_o     = (state_q == S_EVAL) || (state_q == S_UPDATE);
  assign done_o     = (state_q == S_DONE);
  assign found_o    = found_q;
  assign best_seq_o = best_seq_q;
  assign best_e_o   = best_e_q;
  assign eval_cnt_o = eval_cnt_q;

endmodule

// File: tb/tb_labs_range_search.sv
// tb/tb_labs_range_search.sv - scoreboard bench for labs_range_search
module tb_labs_range_search;

  typedef struct {
    int seq;
    int e;
    int cnt;
    int found;
    int lat;
    int t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: N=4, E_WIDTH=16
  logic        start_a = 0, abort_a = 0, mode_a = 0;
  logic [3:0]  cs_a = 0, ce_a = 0, cst_a = 0;
  logic [15:0] th_a = 0;
  logic        busy_a, done_a, found_a;
  logic [3:0]  bseq_a;
  logic [15:0] be_a;
  logic [4:0]  cnt_a;
  // Instance B: N=16, E_WIDTH=8
  logic        start_b = 0, abort_b = 0, mode_b = 0;
  logic [15:0] cs_b = 0, ce_b = 0, cst_b = 0;
  logic [7:0]  th_b = 0;
  logic        busy_b, done_b, found_b;
  logic [15:0] bseq_b;
  logic [7:0]  be_b;
  logic [16:0] cnt_b;
  // Instance C: N=8, E_WIDTH=16
  logic        start_c = 0, abort_c = 0, mode_c = 0;
  logic [7:0]  cs_c = 0, ce_c = 0, cst_c = 0;
  logic [15:0] th_c = 0;
  logic        busy_c, done_c, found_c;
  logic [7:0]  bseq_c;
  logic [15:0] be_c;
  logic [8:0]  cnt_c;

  labs_range_search #(.SEQ_WIDTH(4), .E_WIDTH(16)) u_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
    .cfg_mode_i(mode_a), .cfg_start_i(cs_a), .cfg_end_i(ce_a), .cfg_stride_i(cst_a),
    .cfg_thresh_i(th_a), .busy_o(busy_a), .done_o(done_a), .found_o(found_a),
    .best_seq_o(bseq_a), .best_e_o(be_a), .eval_cnt_o(cnt_a));

  labs_range_search #(.SEQ_WIDTH(16), .E_WIDTH(8)) u_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
    .cfg_mode_i(mode_b), .cfg_start_i(cs_b), .cfg_end_i(ce_b), .cfg_stride_i(cst_b),
    .cfg_thresh_i(th_b), .busy_o(busy_b), .done_o(done_b), .found_o(found_b),
    .best_seq_o(bseq_b), .best_e_o(be_b), .eval_cnt_o(cnt_b));

  labs_range_search #(.SEQ_WIDTH(8), .E_WIDTH(16)) u_c (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_c), .abort_i(abort_c),
    .cfg_mode_i(mode_c), .cfg_start_i(cs_c), .cfg_end_i(ce_c), .cfg_stride_i(cst_c),
    .cfg_thresh_i(th_c), .busy_o(busy_c), .done_o(done_c), .found_o(found_c),
    .best_seq_o(bseq_c), .best_e_o(be_c), .eval_cnt_o(cnt_c));

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t x, input longint seq,
                       input longint en, input longint cnt, input longint fnd);
    chk({tag, " best_seq"}, seq, x.seq);
    chk({tag, " best_e"}, en, x.e);
    chk({tag, " eval_cnt"}, cnt, x.cnt);
    chk({tag, " found"}, fnd, x.found);
    chk({tag, " done latency"}, cyc - x.t0, x.lat);
  endtask

  task automatic unexpected(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s unexpected done_o: got 1 expected 0", tag);
  endtask

  // Monitors: each done_o pulse retires the oldest expected result.
  exp_t m_a, m_b, m_c;
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (q_a.size() == 0) unexpected("A");
      else begin m_a = q_a.pop_front(); score("A", m_a, bseq_a, be_a, cnt_a, found_a); end
    end
    if (rst_n && done_b) begin
      if (q_b.size() == 0) unexpected("B");
      else begin m_b = q_b.pop_front(); score("B", m_b, bseq_b, be_b, cnt_b, found_b); end
    end
    if (rst_n && done_c) begin
      if (q_c.size() == 0) unexpected("C");
      else begin m_c = q_c.pop_front(); score("C", m_c, bseq_c, be_c, cnt_c, found_c); end
    end
  end

  function automatic exp_t mk(input int seq, input int e, input int cnt,
                              input int found, input int lat);
    exp_t x;
    x.seq = seq; x.e = e; x.cnt = cnt; x.found = found; x.lat = lat; x.t0 = 0;
    return x;
  endfunction

  // Reference energy from the +1/-1 product definition.
  function automatic int lab_e(input int n, input int s);
    int tot, c, ai, aj;
    tot = 0;
    for (int k = 1; k < n; k++) begin
      c = 0;
      for (int i = 0; i < n - k; i++) begin
        ai = ((s >> i) & 1) ? -1 : 1;
        aj = ((s >> (i + k)) & 1) ? -1 : 1;
        c += ai * aj;
      end
      tot += c * c;
    end
    return tot;
  endfunction

  function automatic exp_t model_c(input int mode, input int s, input int e,
                                   input int st, input int th);
    exp_t x;
    int cur, en, stp;
    x = mk(0, 65535, 0, 0, 1);
    if (e < s) return x;
    stp = (st == 0) ? 1 : st;
    cur = s;
    forever begin
      en = lab_e(8, cur);
      x.cnt++;
      if ((mode == 1 && en <= th) || en < x.e) begin x.seq = cur; x.e = en; end
      if (mode == 1 && en <= th) begin x.found = 1; break; end
      cur += stp;
      if (cur > e) break;
    end
    x.lat = 1 + 8 * x.cnt;
    return x;
  endfunction

  task automatic launch_a(input int mode, input int s, input int e, input int st,
                          input int th, input exp_t x, input bit push);
    @(posedge clk); #1;
    start_a = 1; mode_a = mode[0]; cs_a = 4'(s); ce_a = 4'(e); cst_a = 4'(st); th_a = 16'(th);
    x.t0 = cyc;
    if (push) q_a.push_back(x);
    @(posedge clk); #1;
    start_a = 0;
  endtask

  task automatic launch_c(input int mode, input int s, input int e, input int st,
                          input int th);
    exp_t x;
    x = model_c(mode, s, e, st, th);
    @(posedge clk); #1;
    start_c = 1; mode_c = mode[0]; cs_c = 8'(s); ce_c = 8'(e); cst_c = 8'(st); th_c = 16'(th);
    x.t0 = cyc;
    q_c.push_back(x);
    @(posedge clk); #1;
    start_c = 0;
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: %0d results outstanding, expected 0",
               tag, q_a.size() + q_b.size() + q_c.size());
      q_a.delete(); q_b.delete(); q_c.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int t0, s, e;
    #12;
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset found", found_a, 0);
    chk("reset best_seq", bseq_a, 0);
    chk("reset best_e A", be_a, 16'hFFFF);
    chk("reset best_e B", be_b, 8'hFF);
    chk("reset eval_cnt", cnt_a, 0);
    @(negedge clk);
    rst_n = 1;

    // Full N=4 sweep; a start pulse with different cfg while busy must be ignored.
    launch_a(0, 0, 15, 1, 0, mk(1, 2, 16, 0, 65), 1);
    repeat (20) @(posedge clk);
    #1;
    start_a = 1; cs_a = 4'd9; ce_a = 4'd9; cst_a = 4'd3; mode_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    drain("A full sweep");

    launch_a(1, 0, 15, 1, 2, mk(1, 2, 2, 1, 9), 1);
    drain("A mode1 hit");
    launch_a(0, 2, 15, 2, 0, mk(2, 2, 7, 0, 29), 1);
    drain("A stride2");
    launch_a(0, 14, 15, 4, 0, mk(14, 2, 1, 0, 5), 1);
    drain("A one candidate");
    launch_a(0, 5, 7, 0, 0, mk(7, 2, 3, 0, 13), 1);
    drain("A stride0");
    launch_a(0, 15, 15, 1, 0, mk(15, 14, 1, 0, 5), 1);
    drain("A all-ones");
    launch_a(0, 5, 3, 1, 0, mk(0, 65535, 0, 0, 1), 1);
    drain("A end<start");

    // Abort 10 cycles into a full sweep: two candidates completed, no done_o.
    launch_a(0, 0, 15, 1, 0, mk(0, 0, 0, 0, 0), 0);
    t0 = cyc - 1;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    chk("abort busy before", busy_a, 1);
    abort_a = 1;
    @(posedge clk); #1;
    abort_a = 0;
    chk("abort busy after", busy_a, 0);
    chk("abort eval_cnt", cnt_a, 2);
    chk("abort best_seq", bseq_a, 1);
    chk("abort best_e", be_a, 2);
    repeat (80) @(posedge clk);

    // Saturating energy on N=16 / E_WIDTH=8.
    @(posedge clk); #1;
    start_b = 1; mode_b = 1; cs_b = 0; ce_b = 0; cst_b = 1; th_b = 8'd10;
    begin
      exp_t xb;
      xb = mk(0, 255, 1, 0, 17);
      xb.t0 = cyc;
      q_b.push_back(xb);
    end
    @(posedge clk); #1;
    start_b = 0;
    drain("B clamp");

    // N=8 sweeps against the reference model.
    launch_c(0, 250, 255, 3, 0);
    drain("C top of range");
    for (int r = 0; r < 4; r++) begin
      s = $urandom_range(0, 255);
      e = s + $urandom_range(0, 30);
      if (e > 255) e = 255;
      launch_c(0, s, e, $urandom_range(0, 4), 0);
      drain("C random");
    end
    launch_c(1, $urandom_range(0, 100), 255, 1, $urandom_range(8, 20));
    drain("C mode1");

    // Asynchronous reset mid-EVAL.
    launch_a(0, 0, 15, 1, 0, mk(0, 0, 0, 0, 0), 0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("async rst busy", busy_a, 0);
    chk("async rst best_seq", bseq_a, 0);
    chk("async rst best_e", be_a, 16'hFFFF);
    chk("async rst eval_cnt", cnt_a, 0);
    chk("async rst found", found_a, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
